// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode-class helpers for the Trireme
// execute-stage ALU.
package alu_pkg;

  localparam logic [5:0] ALU_ADD    = 6'd0,  ALU_PASS_A = 6'd1,  ALU_EQ     = 6'd2,
                         ALU_NE     = 6'd3,  ALU_SLT    = 6'd4,  ALU_SGE    = 6'd5,
                         ALU_SLTU   = 6'd6,  ALU_SGEU   = 6'd7,  ALU_XOR    = 6'd8,
                         ALU_OR     = 6'd9,  ALU_AND    = 6'd10, ALU_SLL    = 6'd11,
                         ALU_SRL    = 6'd12, ALU_SRA    = 6'd13, ALU_SUB    = 6'd14,
                         ALU_MUL    = 6'd15, ALU_MULH   = 6'd16, ALU_MULHSU = 6'd17,
                         ALU_MULHU  = 6'd18, ALU_DIV    = 6'd19, ALU_DIVU   = 6'd20,
                         ALU_REM    = 6'd21, ALU_REMU   = 6'd22;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_ITER = 2'd2,
    DIV_FIX  = 2'd3
  } alu_state_e;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_mul(input logic [5:0] op);
    return (op >= ALU_MUL) && (op <= ALU_MULHU);
  endfunction

endpackage

// File: rtl/alu_serial_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle for
// DATA_WIDTH cycles after start; abort drops the operation.
module alu_serial_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic                  running;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   diff;

  // quo_q starts as the dividend and shifts quotient bits in from the right.
  assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff      = rem_shift - {1'b0, divisor_q};

  // done marks the final iteration; quotient/remainder are complete next cycle.
  assign done      = running && (count == CW'(DATA_WIDTH - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      running   <= 1'b0;
      count     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
    end else if (start) begin
      running   <= 1'b1;
      count     <= '0;
      quo_q     <= dividend;
      rem_q     <= '0;
      divisor_q <= divisor;
    end else if (running) begin
      quo_q <= {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
      rem_q <= diff[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
      count <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Registered execute-stage ALU for the Trireme cores: single-cycle base ops,
// pipelined multiply and serial divide behind a valid/ready issue port.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int MUL_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [5:0]            ALU_operation,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  input  logic                  flush,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] ALU_result,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  localparam int         PIPE_DEPTH = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
  localparam logic [1:0] MUL_LAST   = (MUL_LATENCY > 1) ? 2'(MUL_LATENCY - 2) : 2'd0;

  alu_state_e            state, state_next;
  logic                  accept;
  logic                  load_result;
  logic [DATA_WIDTH-1:0] result_next;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  result_valid_q;
  logic [1:0]            mul_cnt;

  // Handshake: an op is taken on a cycle where op_valid && op_ready; issue
  // holds op_valid and the operands stable until then. result_valid is a
  // one-cycle pulse with no back-pressure from writeback.
  assign op_ready = (reset || (state == IDLE)) && !flush;
  assign accept   = op_valid && op_ready;

  // Outputs read as idle for the whole reset cycle, not only after it.
  assign result_valid = result_valid_q && !reset;
  assign ALU_result   = reset ? '0 : result_q;
  assign busy         = (state != IDLE) && !reset;
  assign fsm_state    = state;

  function automatic logic [DATA_WIDTH-1:0] base_result(input logic [5:0] op,
                                                       input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (op)
      ALU_ADD:    r = a + b;
      ALU_PASS_A: r = a;
      ALU_EQ:     r[0] = (a == b);
      ALU_NE:     r[0] = (a != b);
      ALU_SLT:    r[0] = ($signed(a) < $signed(b));
      ALU_SGE:    r[0] = ($signed(a) >= $signed(b));
      ALU_SLTU:   r[0] = (a < b);
      ALU_SGEU:   r[0] = (a >= b);
      ALU_XOR:    r = a ^ b;
      ALU_OR:     r = a | b;
      ALU_AND:    r = a & b;
      ALU_SLL:    r = a << b[SHAMT_WIDTH-1:0];
      ALU_SRL:    r = a >> b[SHAMT_WIDTH-1:0];
      ALU_SRA:    r = $signed(a) >>> b[SHAMT_WIDTH-1:0];
      ALU_SUB:    r = a - b;
      default:    r = '0;
    endcase
    return r;
  endfunction

  // Multiply: sign-extending both operands to 2*DATA_WIDTH gives the same
  // low 2*DATA_WIDTH bits as the (DATA_WIDTH+1)-bit signed product.
  logic                  mul_a_sign, mul_b_sign;
  logic [2*DATA_WIDTH-1:0] mul_a, mul_b, mul_full;
  logic [DATA_WIDTH-1:0] mul_sel;
  logic [DATA_WIDTH-1:0] mul_pipe [PIPE_DEPTH];

  assign mul_a_sign = (ALU_operation != ALU_MULHU) && operand_A[DATA_WIDTH-1];
  assign mul_b_sign = (ALU_operation == ALU_MULH) && operand_B[DATA_WIDTH-1];
  assign mul_a      = {{DATA_WIDTH{mul_a_sign}}, operand_A};
  assign mul_b      = {{DATA_WIDTH{mul_b_sign}}, operand_B};
  assign mul_full   = mul_a * mul_b;
  assign mul_sel    = (ALU_operation == ALU_MUL) ? mul_full[DATA_WIDTH-1:0]
                                                 : mul_full[2*DATA_WIDTH-1:DATA_WIDTH];

  // Divide: magnitudes go to the serial divider, signs are reapplied in DIV_FIX.
  logic                  div_signed, div_rem_op, sign_a, sign_b;
  logic                  div_by_zero, div_ovf, div_special, div_start, div_done;
  logic [DATA_WIDTH-1:0] mag_a, mag_b, special_result;
  logic [DATA_WIDTH-1:0] div_quo, div_rem, div_fixed;
  logic                  div_neg_quo, div_neg_rem, div_is_rem;

  assign div_signed  = (ALU_operation == ALU_DIV) || (ALU_operation == ALU_REM);
  assign div_rem_op  = (ALU_operation == ALU_REM) || (ALU_operation == ALU_REMU);
  assign sign_a      = div_signed && operand_A[DATA_WIDTH-1];
  assign sign_b      = div_signed && operand_B[DATA_WIDTH-1];
  assign mag_a       = sign_a ? -operand_A : operand_A;
  assign mag_b       = sign_b ? -operand_B : operand_B;
  assign div_by_zero = (operand_B == '0);
  assign div_ovf     = div_signed && (operand_A == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                       && (operand_B == '1);
  assign div_special = div_by_zero || div_ovf;
  assign special_result = div_by_zero ? (div_rem_op ? operand_A : '1)
                                      : (div_rem_op ? '0 : operand_A);
  assign div_fixed   = div_is_rem ? (div_neg_rem ? -div_rem : div_rem)
                                  : (div_neg_quo ? -div_quo : div_quo);

  alu_serial_divider #(.DATA_WIDTH(DATA_WIDTH)) u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .abort     (flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_next  = state;
    load_result = 1'b0;
    result_next = '0;
    div_start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!is_muldiv(ALU_operation)) begin
            load_result = 1'b1;
            result_next = base_result(ALU_operation, operand_A, operand_B);
          end else if (is_mul(ALU_operation)) begin
            if (MUL_LATENCY == 1) begin
              load_result = 1'b1;
              result_next = mul_sel;
            end else begin
              state_next = MUL_WAIT;
            end
          end else if (div_special) begin
            load_result = 1'b1;
            result_next = special_result;
          end else begin
            div_start  = 1'b1;
            state_next = DIV_ITER;
          end
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          state_next = IDLE;
        end else if (mul_cnt == MUL_LAST) begin
          load_result = 1'b1;
          result_next = mul_pipe[PIPE_DEPTH-1];
          state_next  = IDLE;
        end
      end
      DIV_ITER: begin
        if (flush) state_next = IDLE;
        else if (div_done) state_next = DIV_FIX;
      end
      DIV_FIX: begin
        state_next = IDLE;
        if (!flush) begin
          load_result = 1'b1;
          result_next = div_fixed;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      mul_cnt        <= '0;
      div_neg_quo    <= 1'b0;
      div_neg_rem    <= 1'b0;
      div_is_rem     <= 1'b0;
      for (int i = 0; i < PIPE_DEPTH; i++) mul_pipe[i] <= '0;
    end else begin
      state          <= state_next;
      result_valid_q <= load_result;
      if (load_result) result_q <= result_next;
      mul_cnt <= (state == MUL_WAIT) ? mul_cnt + 2'd1 : 2'd0;
      // Stage i holds the product accepted i+1 cycles ago.
      mul_pipe[0] <= mul_sel;
      for (int i = 1; i < PIPE_DEPTH; i++) mul_pipe[i] <= mul_pipe[i-1];
      if (div_start) begin
        div_neg_quo <= sign_a ^ sign_b;
        div_neg_rem <= sign_a;
        div_is_rem  <= div_rem_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit (DATA_WIDTH=32, MUL_LATENCY=2).
module tb_alu_muldiv_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0;
  logic         flush = 1'b0;
  logic [5:0]   ALU_operation = '0;
  logic [W-1:0] operand_A = '0;
  logic [W-1:0] operand_B = '0;
  logic         op_ready, result_valid, busy;
  logic [W-1:0] ALU_result;
  logic [1:0]   fsm_state;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];

  alu_muldiv_unit #(.DATA_WIDTH(W), .SHAMT_WIDTH(5), .MUL_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .ALU_operation(ALU_operation), .operand_A(operand_A), .operand_B(operand_B),
    .flush(flush), .result_valid(result_valid), .ALU_result(ALU_result),
    .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid      = 1'b1;
    ALU_operation = op;
    operand_A     = a;
    operand_B     = b;
  endtask

  // Issue one op, wait (bounded) for result_valid, check latency and value.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_val, input int exp_lat);
    int lat;
    drive(op, a, b);
    check({tag, " ready"}, op_ready, 1);
    tick();
    op_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " value"}, ALU_result, exp_val);
  endtask

  // Reference for the ops used in the random sequence.
  function automatic logic [W-1:0] model(input logic [5:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_AND: return a & b;
      ALU_SRL: return a >> b[4:0];
      ALU_EQ:  return (a == b) ? 32'd1 : 32'd0;
      ALU_SGE: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [5:0]   seq [6];
    logic [5:0]   b2b_op [3];
    logic [W-1:0] b2b_a [3];
    logic [W-1:0] b2b_b [3];
    logic [W-1:0] b2b_e [3];
    logic [W-1:0] ra, rb;
    int           lat, ready_hi, seen;

    seq    = '{ALU_ADD, ALU_AND, ALU_SRL, ALU_EQ, ALU_ADD, ALU_SGE};
    b2b_op = '{ALU_ADD, ALU_SUB, ALU_SRA};
    b2b_a  = '{32'd5, 32'd3, 32'h8000_0000};
    b2b_b  = '{32'd7, 32'd5, 32'd4};
    b2b_e  = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000};

    // Reset state, during and right after reset.
    repeat (3) tick();
    check("rst valid", result_valid, 0);
    check("rst result", ALU_result, 0);
    check("rst busy", busy, 0);
    check("rst ready", op_ready, 1);
    reset = 1'b0;
    #1;
    check("post rst valid", result_valid, 0);
    check("post rst state", fsm_state, IDLE);
    check("post rst ready", op_ready, 1);

    // Back-to-back base ops, full throughput.
    for (int i = 0; i < 3; i++) begin
      drive(b2b_op[i], b2b_a[i], b2b_b[i]);
      check("b2b ready", op_ready, 1);
      tick();
      check("b2b valid", result_valid, 1);
      check("b2b value", ALU_result, b2b_e[i]);
    end
    op_valid = 1'b0;
    tick();
    check("b2b pulse end", result_valid, 0);
    check("b2b hold", ALU_result, 32'hF800_0000);

    // Random operand sequence against the reference.
    for (int r = 0; r < 50; r++) begin
      for (int k = 0; k < 6; k++) begin
        ra = $urandom;
        rb = $urandom;
        if (seq[k] == ALU_EQ && (r % 2 == 1)) rb = ra;
        drive(seq[k], ra, rb);
        exp_q.push_back(model(seq[k], ra, rb));
        tick();
        check("seq valid", result_valid, 1);
        check("seq value", ALU_result, exp_q.pop_front());
      end
    end
    op_valid = 1'b0;
    tick();

    // Remaining base ops, including shift amount taken from low 5 bits.
    run_op("pass", ALU_PASS_A, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 1);
    run_op("ne", ALU_NE, 32'd5, 32'd5, 32'd0, 1);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("sgeu", ALU_SGEU, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("xor", ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1);
    run_op("or", ALU_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1);
    run_op("sll", ALU_SLL, 32'd1, 32'h23, 32'd8, 1);
    run_op("unused op", 6'd40, 32'd3, 32'd4, 32'd0, 1);

    // Multiply family.
    run_op("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2);
    run_op("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("mul wrap", ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 2);
    run_op("mul", ALU_MUL, 32'd1234, 32'd5678, 32'd7006652, 2);

    // DIV -7/2 with a follow-on op held on the port throughout.
    drive(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    tick();
    check("div state", fsm_state, DIV_ITER);
    check("div busy", busy, 1);
    drive(ALU_ADD, 32'd1, 32'd1);
    ready_hi = 0;
    lat = 1;
    while (!result_valid && lat < 100) begin
      if (op_ready) ready_hi++;
      tick();
      lat++;
    end
    check("div latency", lat, 34);
    check("div value", ALU_result, 32'hFFFF_FFFD);
    check("div ready low cycles", ready_hi, 0);
    check("div ready at result", op_ready, 1);
    tick();
    op_valid = 1'b0;
    check("held op valid", result_valid, 1);
    check("held op value", ALU_result, 32'd2);

    run_op("rem -7/2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("div 7/-2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("rem 7/-2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("divu", ALU_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
    run_op("remu", ALU_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 34);
    run_op("div min/2", ALU_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);

    // Divide special cases resolve in one cycle.
    run_op("divu by 0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu by 0", ALU_REMU, 32'd9, 32'd0, 32'd9, 1);
    run_op("div by 0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem by 0", ALU_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush mid-divide.
    run_op("pre flush", ALU_ADD, 32'h1234, 32'd0, 32'h1234, 1);
    drive(ALU_DIV, 32'd100, 32'd3);
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    check("flush ready low", op_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    check("flush ready", op_ready, 1);
    check("flush busy", busy, 0);
    seen = 0;
    repeat (40) begin
      if (result_valid) seen++;
      tick();
    end
    check("flush no result", seen, 0);
    check("flush hold", ALU_result, 32'h1234);

    // Flush together with op_valid: not accepted.
    drive(ALU_ADD, 32'd1, 32'd1);
    flush = 1'b1;
    #1;
    check("flush+valid ready", op_ready, 0);
    tick();
    flush = 1'b0;
    op_valid = 1'b0;
    check("flush+valid result", result_valid, 0);
    check("flush+valid hold", ALU_result, 32'h1234);

    // Flush in the cycle a multiply result would be registered.
    drive(ALU_MUL, 32'd3, 32'd4);
    tick();
    op_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 0;
    repeat (5) begin
      if (result_valid) seen++;
      tick();
    end
    check("mul flush no result", seen, 0);
    check("mul flush hold", ALU_result, 32'h1234);

    // Reset mid-divide.
    drive(ALU_DIV, 32'd100, 32'd3);
    tick();
    op_valid = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    #1;
    check("mid rst result", ALU_result, 0);
    check("mid rst busy", busy, 0);
    check("mid rst ready", op_ready, 1);
    tick();
    reset = 1'b0;
    #1;
    check("after rst result", ALU_result, 0);
    check("after rst valid", result_valid, 0);
    check("after rst busy", busy, 0);
    check("after rst ready", op_ready, 1);
    seen = 0;
    repeat (40) begin
      if (result_valid) seen++;
      tick();
    end
    check("after rst no result", seen, 0);

    run_op("div 100/3", ALU_DIV, 32'd100, 32'd3, 32'd33, 34);
    run_op("rem 100/3", ALU_REM, 32'd100, 32'd3, 32'd1, 34);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Parametrised, registered execute-stage unit for the Trireme cores. It implements the existing 6-bit base ALU opcodes (0-14) plus the RV32M/RV64M multiply/divide opcodes (15-22). It is the next-generation ALU for the pipelined cores, with a valid/ready issue handshake, multi-cycle multiply and divide, and a flush input for branch mispredict or exception squash. It sits between the decode/issue stage and writeback; the issue logic stalls on op_ready low.

Parameters:
DATA_WIDTH, 32, operand/result width; 32 or 64 only.
SHAMT_WIDTH, 5, shift-amount bits taken from operand_B; must equal log2(DATA_WIDTH).
MUL_LATENCY, 2, cycles from accept to result for MUL*; legal range 1-4.

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high reset
op_valid  input  1  issue request
op_ready  output  1  unit can accept; op_valid&&op_ready = accept
ALU_operation  input  6  opcode, sampled on accept
operand_A  input  DATA_WIDTH  source A, sampled on accept
operand_B  input  DATA_WIDTH  source B, sampled on accept
flush  input  1  squash any in-flight op
result_valid  output  1  one-cycle pulse; ALU_result valid
ALU_result  output  DATA_WIDTH  registered result; holds last value
busy  output  1  multi-cycle op in flight

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While reset is high, and in the cycle after, result_valid=0, ALU_result=0, busy=0, op_ready=1, FSM=IDLE. Reset mid-divide or mid-multiply discards the op with no result_valid.
- Base opcode map:
  - 0 ADD; 1 pass A; 2 EQ; 3 NE; 4 SLT signed; 5 SGE signed; 6 SLTU; 7 SGEU.
  - 8 XOR; 9 OR; 10 AND; 11 SLL; 12 SRL; 13 SRA; 14 SUB.
  - Compare results are 1/0, zero-extended. Shifts use operand_B[SHAMT_WIDTH-1:0]. Arithmetic wraps modulo 2^DATA_WIDTH.
- M-extension opcode map:
  - 15 MUL (low half); 16 MULH (signed x signed, high); 17 MULHSU (signed A x unsigned B, high); 18 MULHU (high).
  - 19 DIV; 20 DIVU; 21 REM; 22 REMU. All divide/remainder ops truncate toward zero.
  - Opcodes 23-63 produce 0 with base-op latency.
- Result is a pure function of opcode and operands. No dependence on operation history, and no hidden state beyond the FSM and datapath registers.
- Latency, with accept at cycle 0:
  - Base ops: result_valid in cycle 1.
  - MUL*: result_valid in cycle MUL_LATENCY.
  - DIV*/REM*: result_valid in cycle DATA_WIDTH+2.
  - Divide special cases (below): result_valid in cycle 1.
- op_ready = (state==IDLE) && !flush. Back-to-back base ops are accepted every cycle at full throughput.
- FSM states:
  - IDLE: on accept of base op or divide special case, register the result and stay in IDLE. On MUL*, go to MUL_WAIT. On DIV*/REM*, go to DIV_ITER.
  - MUL_WAIT: count MUL_LATENCY-1 cycles, then assert result_valid and return to IDLE. With MUL_LATENCY=1, the multiply completes like a base op and MUL_WAIT is skipped.
  - DIV_ITER: DATA_WIDTH radix-2 restoring iterations on operand magnitudes, then go to DIV_FIX.
  - DIV_FIX: apply sign correction (quotient sign = sA^sB; remainder sign = sA), register the result, assert result_valid, return to IDLE.
- busy = state!=IDLE.
- Divide special cases, resolved at accept without iterating:
  - B==0: DIV/DIVU give all-ones; REM/REMU give A.
  - Signed overflow (A = most-negative, B = -1): DIV gives A; REM gives 0.
- Flush:
  - Flush while busy: the next state is IDLE and no result_valid is issued for the squashed op.
  - Flush in the cycle a result would be asserted: that result_valid is suppressed and ALU_result is unchanged.
  - Flush together with op_valid: the op is not accepted (op_ready is low).
- op_valid while busy: ignored; issue must hold it. Operands are captured only on accept; input changes after accept have no effect.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams ALU_ADD...ALU_REMU (0-22).
  - FSM state encodings IDLE/MUL_WAIT/DIV_ITER/DIV_FIX.
  - Helper function is_muldiv(op).
- Sub-module alu_serial_divider: unsigned magnitude restoring divider with start/done, a DATA_WIDTH-cycle iteration counter and abort input. Sign handling stays in the top.
- The multiplier is a DATA_WIDTH+1 signed product with a MUL_LATENCY-deep register pipeline, inline in the top.

Test Plan:
- Reset, then back-to-back ADD 5+7, SUB 3-5, SRA 0x80000000 by 4 on consecutive cycles -> result_valid on 3 consecutive cycles with 12, 0xFFFFFFFE, 0xF8000000; op_ready stays 1.
- Sequence ADD, AND, SRL, EQ, ADD, SGE repeated 50 times with random operands -> every result matches the golden model; no sticky or constant output ever appears.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0 in cycle 2 (MUL_LATENCY=2); MULHU with the same operands -> 0xFFFFFFFE; MUL 0x10000 x 0x10000 -> 0.
- DIV -7/2 -> result_valid in cycle 34 with 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. op_ready is 0 during cycles 1-33, and an op_valid held during that time is accepted in cycle 34.
- DIVU 9/0 -> 0xFFFFFFFF in cycle 1; REMU 9/0 -> 9; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- Start DIV 100/3 and assert flush in cycle 10 -> no result_valid, ALU_result unchanged, op_ready=1 in cycle 11. Repeat with reset instead of flush in cycle 20 -> all outputs 0.
